// File: rtl/life_window_if.sv
// Handshake and window bundle for life_window_gen. LIFE_FRAMECNT_EN adds frame_cnt.
// The master is the window generator; the slave is the surrounding environment.
interface life_window_if #(
  parameter int XW = 5,
  parameter int YW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic          in_cell;
  logic          out_valid;
  logic          out_ready;
  logic          Tl, T, Tr, L, C, R, Bl, B, Br;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          out_last;
`ifdef LIFE_FRAMECNT_EN
  logic [15:0]   frame_cnt;

  modport master (
    input  in_valid, in_cell, out_ready,
    output in_ready, out_valid, Tl, T, Tr, L, C, R, Bl, B, Br,
    output out_x, out_y, out_last, frame_cnt
  );
  modport slave (
    output in_valid, in_cell, out_ready,
    input  in_ready, out_valid, Tl, T, Tr, L, C, R, Bl, B, Br,
    input  out_x, out_y, out_last, frame_cnt
  );
`else
  modport master (
    input  in_valid, in_cell, out_ready,
    output in_ready, out_valid, Tl, T, Tr, L, C, R, Bl, B, Br,
    output out_x, out_y, out_last
  );
  modport slave (
    output in_valid, in_cell, out_ready,
    input  in_ready, out_valid, Tl, T, Tr, L, C, R, Bl, B, Br,
    input  out_x, out_y, out_last
  );
`endif
endinterface

// File: rtl/life_window_gen.sv
// Streaming 3x3 Game-of-Life neighbourhood generator over a raster-ordered frame.
// Optional macro LIFE_FRAMECNT_EN adds a 16-bit frame counter on the interface.
//
// state  | meaning
// FILL   | accept the first WIDTH+1 cells, no output yet
// STREAM | one accepted cell loads one window
// FLUSH  | shift zeros to emit the last WIDTH+1 windows
module life_window_gen #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int XW     = 5,
  parameter int YW     = 5
) (
  input  logic          clk,
  input  logic          rst,
  life_window_if.master bus
);
  localparam int N  = WIDTH * HEIGHT;
  localparam int HL = 2 * WIDTH + 3;
  localparam int KW = $clog2(N);

  typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;

  state_t        state, state_nx;
  // The incoming bit plus the stored bits together form the 2*WIDTH+3 history.
  logic [HL-2:0] hist;
  logic [HL-1:0] hist_nx;
  logic [KW-1:0] k;
  logic [XW-1:0] lx;
  logic [YW-1:0] ly;
  logic          loaded_all;
  logic          rdy, shift, shift_bit, load, drain;
  logic          x0, xe, y0, ye, k_end;
  logic          out_valid_q, out_last_q;
  logic [8:0]    win_q, win_nx;
  logic [XW-1:0] out_x_q;
  logic [YW-1:0] out_y_q;

  assign drain   = out_valid_q & bus.out_ready;
  assign k_end   = (k == KW'(N - 1));
  assign x0      = (lx == '0);
  assign xe      = (lx == XW'(WIDTH - 1));
  assign y0      = (ly == '0);
  assign ye      = (ly == YW'(HEIGHT - 1));
  assign hist_nx = {hist, shift_bit};

  always_comb begin
    state_nx  = state;
    rdy       = 1'b0;
    shift     = 1'b0;
    shift_bit = 1'b0;
    load      = 1'b0;
    case (state)
      FILL: begin
        rdy       = 1'b1;
        shift     = bus.in_valid;
        shift_bit = bus.in_cell;
        if (bus.in_valid && k == KW'(WIDTH)) state_nx = STREAM;
      end
      STREAM: begin
        rdy       = bus.out_ready | ~out_valid_q;
        shift     = bus.in_valid & rdy;
        shift_bit = bus.in_cell;
        load      = shift;
        if (shift && k_end) state_nx = FLUSH;
      end
      FLUSH: begin
        if (!loaded_all && (drain || !out_valid_q)) begin
          shift = 1'b1;
          load  = 1'b1;
        end
        if (drain && out_last_q) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  // Window taken from the post-shift history; centre sits at index WIDTH+1.
  always_comb begin
    win_nx = '0;
    win_nx[8] = hist_nx[2*WIDTH+2] & ~x0 & ~y0;
    win_nx[7] = hist_nx[2*WIDTH+1] & ~y0;
    win_nx[6] = hist_nx[2*WIDTH]   & ~xe & ~y0;
    win_nx[5] = hist_nx[WIDTH+2]   & ~x0;
    win_nx[4] = hist_nx[WIDTH+1];
    win_nx[3] = hist_nx[WIDTH]     & ~xe;
    win_nx[2] = hist_nx[2]         & ~x0 & ~ye;
    win_nx[1] = hist_nx[1]         & ~ye;
    win_nx[0] = hist_nx[0]         & ~xe & ~ye;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      hist        <= '0;
      k           <= '0;
      lx          <= '0;
      ly          <= '0;
      loaded_all  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      win_q       <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      state <= state_nx;
      if (shift) hist <= hist_nx[HL-2:0];
      if (shift && state != FLUSH) k <= k_end ? '0 : k + 1'b1;
      if (load) begin
        win_q       <= win_nx;
        out_x_q     <= lx;
        out_y_q     <= ly;
        out_last_q  <= xe & ye;
        out_valid_q <= 1'b1;
        if (xe) begin
          lx <= '0;
          ly <= ye ? '0 : ly + 1'b1;
        end else begin
          lx <= lx + 1'b1;
        end
        if (xe && ye) loaded_all <= 1'b1;
      end else if (drain) begin
        out_valid_q <= 1'b0;
      end
      if (state == FLUSH && state_nx == FILL) loaded_all <= 1'b0;
    end
  end

`ifdef LIFE_FRAMECNT_EN
  logic [15:0] frame_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_cnt_q <= '0;
    else if (drain && out_last_q) frame_cnt_q <= frame_cnt_q + 16'd1;
  end
  assign bus.frame_cnt = frame_cnt_q;
`endif

  assign bus.in_ready  = rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
  assign {bus.Tl, bus.T, bus.Tr, bus.L, bus.C, bus.R, bus.Bl, bus.B, bus.Br} = win_q;
endmodule

// File: tb/tb_life_window_gen.sv
// Scoreboard bench for life_window_gen on a 4x3 grid.
// Expected windows come from a grid model pushed per frame; a negedge monitor pops them.
module tb_life_window_gen;
  localparam int W = 4;
  localparam int H = 3;

  logic clk = 1'b0;
  logic rst;

  life_window_if #(.XW(2), .YW(2)) bus ();

  life_window_gen #(.WIDTH(W), .HEIGHT(H), .XW(2), .YW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int win_idx  = 0;
  int stalls   = 0;
  int first_valid_cyc = -1;
  int acc6_cyc = -1;
  bit tog_mode = 1'b0;
  bit stall_pending = 1'b0;
  logic [13:0] stall_snap;
  logic [13:0] exp_q[$];
  logic [8:0]  got_win[0:15];

  wire [8:0]  cur_win = {bus.Tl, bus.T, bus.Tr, bus.L, bus.C, bus.R, bus.Bl, bus.B, bus.Br};
  wire [13:0] cur = {bus.out_x, bus.out_y, bus.out_last, cur_win};

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: handshake pops the scoreboard; a stall must hold all outputs.
  initial forever begin
    logic [13:0] e;
    @(negedge clk);
    if (rst) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        checks++;
        if (cur !== stall_snap) begin
          failures++;
          $display("FAIL stable: got %h required %h", cur, stall_snap);
        end
      end
      stall_pending = 1'b0;
      if (bus.out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (!bus.out_ready) begin
          stall_snap    = cur;
          stall_pending = 1'b1;
          stalls++;
        end else begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL extra_window: got %h required none", cur);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              failures++;
              $display("FAIL window %0d: got x/y/last/win %h required %h", win_idx, cur, e);
            end
          end
          if (win_idx < 16) got_win[win_idx] = cur_win;
          win_idx++;
        end
      end
    end
  end

  function automatic logic cellv(input logic [11:0] g, input int x, input int y);
    if (x < 0 || x >= W || y < 0 || y >= H) return 1'b0;
    return g[y*W + x];
  endfunction

  task automatic push_frame(input logic [11:0] g);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back({2'(x), 2'(y), (x == W-1 && y == H-1),
                         cellv(g, x-1, y-1), cellv(g, x, y-1), cellv(g, x+1, y-1),
                         cellv(g, x-1, y),   cellv(g, x, y),   cellv(g, x+1, y),
                         cellv(g, x-1, y+1), cellv(g, x, y+1), cellv(g, x+1, y+1)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.out_ready = tog_mode ? ~bus.out_ready : 1'b1;
  endtask

  task automatic drive_frame(input logic [11:0] g, input int n);
    int i = 0;
    int guard = 0;
    bit hs;
    push_frame(g);
    first_valid_cyc = -1;
    acc6_cyc = -1;
    win_idx = 0;
    bus.in_valid = 1'b1;
    bus.in_cell  = g[0];
    while (i < n && guard < 400) begin
      @(negedge clk);
      hs = bus.in_ready;
      if (hs && i == 5) acc6_cyc = cyc;
      step();
      guard++;
      if (hs) begin
        i++;
        if (i < n) bus.in_cell = g[i];
      end
    end
    bus.in_valid = 1'b0;
    bus.in_cell  = 1'b0;
    checks++;
    if (i != n) begin
      failures++;
      $display("FAIL accept_count: got %0d required %0d", i, n);
    end
  endtask

  task automatic wait_drain(output int zeros);
    int guard = 0;
    zeros = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && guard < 400) begin
      @(negedge clk);
      if (!bus.in_ready) zeros++;
      step();
      guard++;
    end
    checks++;
    if (exp_q.size() != 0 || win_idx != W*H) begin
      failures++;
      $display("FAIL drain: windows got %0d required %0d, left %0d", win_idx, W*H, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_cell = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || cur !== 14'd0) begin
      failures++;
      $display("FAIL reset_state: got valid=%b ready=%b out=%h required 0 1 0", bus.out_valid, bus.in_ready, cur);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_all_ones();
    int z;
    drive_frame(12'hFFF, W*H);
    wait_drain(z);
    checks += 3;
    if (got_win[0] !== 9'b000_011_011) begin
      failures++;
      $display("FAIL ones_00: got %b required %b", got_win[0], 9'b000_011_011);
    end
    if (got_win[5] !== 9'h1FF) begin
      failures++;
      $display("FAIL ones_11: got %b required %b", got_win[5], 9'h1FF);
    end
    if (got_win[11] !== 9'b110_110_000) begin
      failures++;
      $display("FAIL ones_32: got %b required %b", got_win[11], 9'b110_110_000);
    end
  endtask

  task automatic test_single_cell();
    int z;
    drive_frame(12'h040, W*H);
    wait_drain(z);
    checks += 4;
    if (got_win[0] !== 9'd0) begin
      failures++;
      $display("FAIL single_00: got %b required 0", got_win[0]);
    end
    if (got_win[1] !== 9'b000_000_001) begin
      failures++;
      $display("FAIL single_10: got %b required %b", got_win[1], 9'b000_000_001);
    end
    if (got_win[6] !== 9'b000_010_000) begin
      failures++;
      $display("FAIL single_21: got %b required %b", got_win[6], 9'b000_010_000);
    end
    if (got_win[11] !== 9'b100_000_000) begin
      failures++;
      $display("FAIL single_32: got %b required %b", got_win[11], 9'b100_000_000);
    end
  endtask

  task automatic test_latency();
    int z;
    drive_frame(12'($urandom), W*H);
    wait_drain(z);
    checks += 2;
    if (first_valid_cyc != acc6_cyc + 1) begin
      failures++;
      $display("FAIL latency: got cycle %0d required %0d", first_valid_cyc, acc6_cyc + 1);
    end
    if (z != W + 2) begin
      failures++;
      $display("FAIL flush_cycles: got %0d required %0d", z, W + 2);
    end
  endtask

  task automatic test_backpressure();
    int z;
    tog_mode = 1'b1;
    stalls = 0;
    for (int f = 0; f < 2; f++) begin
      drive_frame(12'($urandom), W*H);
      wait_drain(z);
    end
    tog_mode = 1'b0;
    step();
    checks++;
    if (stalls == 0) begin
      failures++;
      $display("FAIL stall_seen: got %0d stalls required >0", stalls);
    end
  endtask

  task automatic test_reset_midframe();
    int z;
    drive_frame(12'hFFF, 7);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_valid: got %b required 1", bus.out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || cur !== 14'd0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_clear: got valid=%b out=%h ready=%b required 0 0 1", bus.out_valid, cur, bus.in_ready);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step();
    drive_frame(12'h000, W*H);
    wait_drain(z);
  endtask

`ifdef LIFE_FRAMECNT_EN
  task automatic test_framecnt();
    int z;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL framecnt_reset: got %h required 0000", bus.frame_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    for (int f = 1; f <= 3; f++) begin
      drive_frame(12'($urandom), W*H);
      wait_drain(z);
      checks++;
      if (bus.frame_cnt !== 16'(f)) begin
        failures++;
        $display("FAIL framecnt_%0d: got %h required %h", f, bus.frame_cnt, 16'(f));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_all_ones();
    test_single_cell();
    test_latency();
    test_backpressure();
    test_reset_midframe();
`ifdef LIFE_FRAMECNT_EN
    test_framecnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
